score_display: RTL

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/score_display.sv | 132 +++++++++++++
 1 files changed

// File: rtl/score_display.sv
// Two-digit score display with a best-score memory and a post-update flash.
// Scans four multiplexed 7-segment digits: current ones, current tens,
// best ones, best tens (an[0] = rightmost). All outputs are active-low.
module score_display #(
  parameter int REFRESH_DIV  = 100000,
  parameter int FLASH_BLINKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       score_update,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  // +2 keeps the width at least 1 even when FLASH_BLINKS is 0
  localparam int FW = $clog2(2 * FLASH_BLINKS + 2);
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FLASH_LOAD = FW'(2 * FLASH_BLINKS);
  localparam logic [6:0]    SEG_BLANK  = 7'b1111111;
  localparam logic [6:0]    SEG_DASH   = 7'b0111111;

  logic [CW-1:0] refresh_q, refresh_d;
  logic [1:0]    idx_q, idx_d;
  logic [FW-1:0] flash_q, flash_d;
  logic [3:0]    cur_ones_q, cur_tens_q;
  logic [7:0]    best_q, best_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic          wrap;
  logic          frame_end;
  logic          cur_valid;
  logic [3:0]    digit_val;
  logic          digit_blank;

  // Segment patterns for BCD digits; anything above 9 shows a dash.
  function automatic logic [6:0] encode(input logic [3:0] v);
    case (v)
      4'd0:    encode = 7'b1000000;
      4'd1:    encode = 7'b1111001;
      4'd2:    encode = 7'b0100100;
      4'd3:    encode = 7'b0110000;
      4'd4:    encode = 7'b0011001;
      4'd5:    encode = 7'b0010010;
      4'd6:    encode = 7'b0000010;
      4'd7:    encode = 7'b1111000;
      4'd8:    encode = 7'b0000000;
      4'd9:    encode = 7'b0010000;
      default: encode = SEG_DASH;
    endcase
  endfunction

  // Next-state for scan timing, flash countdown and best score.
  always_comb begin
    wrap      = (refresh_q == CNT_LAST);
    frame_end = wrap && (idx_q == 2'd3);
    refresh_d = wrap ? '0 : refresh_q + CW'(1);
    idx_d     = wrap ? idx_q + 2'd1 : idx_q;

    // A new score restarts the flash, even on a frame-end cycle.
    flash_d = flash_q;
    if (score_update) begin
      flash_d = FLASH_LOAD;
    end else if (frame_end && (flash_q != '0)) begin
      flash_d = flash_q - FW'(1);
    end

    cur_valid = (cur_ones_q <= 4'd9) && (cur_tens_q <= 4'd9);
    best_d    = best_q;
    if (cur_valid && ({cur_tens_q, cur_ones_q} > best_q)) begin
      best_d = {cur_tens_q, cur_ones_q};
    end
  end

  // Select the scanned digit and work out blanking (leading zero or flash).
  always_comb begin
    digit_val   = cur_ones_q;
    digit_blank = 1'b0;
    case (idx_q)
      2'd0: begin
        digit_val   = cur_ones_q;
        digit_blank = flash_q[0];
      end
      2'd1: begin
        digit_val   = cur_tens_q;
        digit_blank = flash_q[0] || (cur_tens_q == 4'd0);
      end
      2'd2: begin
        digit_val   = best_q[3:0];
        digit_blank = 1'b0;
      end
      default: begin
        digit_val   = best_q[7:4];
        digit_blank = (best_q[7:4] == 4'd0);
      end
    endcase
    seg_d = digit_blank ? SEG_BLANK : encode(digit_val);
    an_d  = ~(4'b0001 << idx_q);
  end

  // State and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_q  <= '0;
      idx_q      <= '0;
      flash_q    <= '0;
      cur_ones_q <= '0;
      cur_tens_q <= '0;
      best_q     <= '0;
      an_q       <= 4'b1111;
      seg_q      <= SEG_BLANK;
    end else begin
      refresh_q  <= refresh_d;
      idx_q      <= idx_d;
      flash_q    <= flash_d;
      cur_ones_q <= ones;
      cur_tens_q <= tens;
      best_q     <= best_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule
